syzygy_dac_tx_framer: RTL
=========================

Name: syzygy_dac_tx_framer

Overview:
Transmit-side counterpart of the SYZYGY ADC capture path. It runs in the divided (1/4-rate) fabric clock that feeds the OSERDES. It buffers incoming sample words, sequences serializer reset, sends a training pattern for DAC-side alignment, then streams samples with midscale fill on underflow. It drives the OSERDES parallel data inputs and the forwarded-clock (DCI) pattern, and sits between the DSP/host sample source and the SYZYGY DAC pin serializers.

Parameters:
DATA_WIDTH, 12, bits per DAC sample (offset binary at output)
FIFO_DEPTH, 16, input FIFO words; power of 2, min 4
FILL_LEVEL, 8, FIFO occupancy required before leaving PRIME; 1..FIFO_DEPTH
RST_CYCLES, 8, cycles oserdes_rst is held high after reset release
TRAIN_LEN, 64, minimum TRAIN cycles
TRAIN_PATTERN, 12'hA5C, per-sample training word (DATA_WIDTH bits)

Ports:
clk  input  1  divided fabric clock (OSERDES CLKDIV domain)
reset_n  input  1  asynchronous active-low reset
enable  input  1  stream enable; low forces IDLE
train_req  input  1  request (re)training; level-sensitive
s_tdata  input  4*DATA_WIDTH  four samples, sample 0 in LSBs, first on wire
s_tvalid  input  1  input word valid
s_tready  output  1  FIFO not full
dac_word  output  4*DATA_WIDTH  registered OSERDES parallel data
dci_pattern  output  8  forwarded-clock OSERDES pattern
oserdes_rst  output  1  serializer reset
streaming  output  1  high in STREAM
underflow_cnt  output  16  saturating count of underflow cycles
fifo_level  output  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (reset_n low, async): state RST_HOLD, FIFO empty, dac_word = midscale (each sample 1<<(DATA_WIDTH-1)), dci_pattern = 8'h00, oserdes_rst = 1, s_tready = 0, streaming = 0, underflow_cnt = 0.
- Accept on s_tvalid & s_tready. s_tready = !full, except 0 in RST_HOLD. Write when full is impossible; s_tvalid while not ready is held by the source.
- States:
  RST_HOLD: counts RST_CYCLES, then oserdes_rst drops and state goes to TRAIN.
  TRAIN: dac_word = TRAIN_PATTERN in all 4 slots. Leaves after >= TRAIN_LEN cycles and train_req low: to PRIME if enable, else IDLE. The FIFO is flushed on entry.
  IDLE: dac_word = midscale. FIFO is still writable. enable high goes to PRIME.
  PRIME: dac_word = midscale. Goes to STREAM at the first edge where fifo_level >= FILL_LEVEL.
  STREAM: one FIFO word is read per cycle. If the FIFO is empty, output midscale and increment underflow_cnt (saturating at 16'hFFFF). Remain in STREAM.
- Any state except RST_HOLD: train_req high goes to TRAIN next cycle; enable low goes to IDLE next cycle (STREAM/PRIME). train_req wins over enable.
- dci_pattern = 8'b01010101 in every state except RST_HOLD (one DDR clock edge per bit slot). It is 8'h00 in RST_HOLD.
- Latency: in STREAM with an empty FIFO, a word accepted at edge t is on dac_word after edge t+2. A non-empty FIFO preserves strict order with no gaps.
- Simultaneous write and read at full: the read frees the slot, but s_tready is still 0 that cycle (registered on the full flag).
- fifo_level is exact. Wrap-around uses log2 pointers plus an extra bit.
- Reset asserted mid-stream: everything returns to the reset values immediately, and in-flight data is discarded.

Optional Feature:
SYZYGY_DAC_TX_TWOS_COMP_EN: when defined, input samples are two's complement and the MSB of each sample is inverted before dac_word (offset binary). TRAIN_PATTERN and midscale are not converted. When undefined, samples pass unmodified.

Test Plan:
- Reset release: oserdes_rst = 1 for exactly 8 cycles, dci_pattern = 8'h00 then 8'h55, dac_word = 48'hA5CA5CA5CA5C for 64 cycles, enable = 0 -> IDLE with 48'h800800800800.
- Prime/stream: enable = 1, push 8 words 0x001..; streaming rises after the 8th write, output order is exact, latency from empty is 2 cycles.
- Underflow: stop s_tvalid for 5 cycles in STREAM -> 5 midscale words, underflow_cnt = 5; force 70000 empty cycles -> holds 16'hFFFF.
- Backpressure: hold s_tvalid with enable = 0 -> s_tready drops after 16 accepts, fifo_level = 16, no words lost after enable.
- Retrain mid-stream: pulse train_req 1 cycle -> TRAIN for 64 cycles, FIFO flushed (fifo_level = 0), then PRIME.
- With SYZYGY_DAC_TX_TWOS_COMP_EN: input sample 12'hFFF (-1) -> output 12'h7FF; 12'h000 -> 12'h800.

Source files
------------

// File: rtl/syzygy_dac_tx_framer.sv
// ---------------------------------------------------------------------------
// syzygy_dac_tx_framer
//
// Transmit framer for a SYZYGY DAC. It runs in the divided (1/4-rate) fabric
// clock that feeds the OSERDES. The framer buffers sample words and holds the
// serializers in reset after reset release. It then sends a training pattern
// for DAC-side alignment. After training it streams samples and fills with
// midscale when the FIFO runs empty.
//
// Optional build macro:
//   SYZYGY_DAC_TX_TWOS_COMP_EN - input samples are two's complement; the MSB of
//   each streamed sample is inverted to give offset binary. Training and
//   midscale words are never converted.
//
// Ports:
//   clk            divided fabric clock (OSERDES CLKDIV domain)
//   reset_n        asynchronous active-low reset
//   enable         stream enable; low sends PRIME/STREAM to IDLE
//   train_req      level-sensitive (re)training request, beats enable
//   s_tdata        four samples, sample 0 in the LSBs (first on the wire)
//   s_tvalid       input word valid
//   s_tready       FIFO can accept (low when full and in RST_HOLD)
//   dac_word       registered OSERDES parallel data
//   dci_pattern    forwarded-clock OSERDES pattern
//   oserdes_rst    serializer reset
//   streaming      high in STREAM
//   underflow_cnt  saturating count of STREAM cycles with an empty FIFO
//   fifo_level     exact FIFO occupancy
//   fsm_state      current FSM state, for debug and checkers
//
// Handshake: a word transfers on a rising clk edge where s_tvalid and s_tready
// are both high. A source that sees s_tready low must hold s_tvalid and
// s_tdata stable until the transfer.
// ---------------------------------------------------------------------------
module syzygy_dac_tx_framer #(
    parameter int                    DATA_WIDTH    = 12,
    parameter int                    FIFO_DEPTH    = 16,
    parameter int                    FILL_LEVEL    = 8,
    parameter int                    RST_CYCLES    = 8,
    parameter int                    TRAIN_LEN     = 64,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 12'hA5C
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          train_req,
    input  logic [4*DATA_WIDTH-1:0]       s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [4*DATA_WIDTH-1:0]       dac_word,
    output logic [7:0]                    dci_pattern,
    output logic                          oserdes_rst,
    output logic                          streaming,
    output logic [15:0]                   underflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [2:0]                    fsm_state
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int WW      = 4 * DATA_WIDTH;
    localparam int CNT_TOP = (RST_CYCLES > TRAIN_LEN) ? RST_CYCLES : TRAIN_LEN;
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [DATA_WIDTH-1:0] MID_SAMPLE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [WW-1:0]         MID_WORD   = {4{MID_SAMPLE}};
    localparam logic [WW-1:0]         TRAIN_WORD = {4{TRAIN_PATTERN}};
    localparam logic [CW-1:0]         CNT_MAX    = '1;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        TRAIN    = 3'd1,
        IDLE     = 3'd2,
        PRIME    = 3'd3,
        STREAM   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, wr_en, rd_en, flush;
    logic [WW-1:0] pipe_word;
    logic [WW-1:0] rd_word;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RST_HOLD: if (cnt == CW'(RST_CYCLES - 1)) state_next = TRAIN;
            TRAIN: begin
                if (!train_req && cnt >= CW'(TRAIN_LEN - 1))
                    state_next = enable ? PRIME : IDLE;
            end
            IDLE: begin
                if (train_req)   state_next = TRAIN;
                else if (enable) state_next = PRIME;
            end
            PRIME: begin
                if (train_req)                          state_next = TRAIN;
                else if (!enable)                       state_next = IDLE;
                else if (fifo_level >= (AW+1)'(FILL_LEVEL)) state_next = STREAM;
            end
            STREAM: begin
                if (train_req)    state_next = TRAIN;
                else if (!enable) state_next = IDLE;
            end
            default: state_next = RST_HOLD;
        endcase
    end

    // Cycles spent in the current state; restarts on every state change, so a
    // train_req held inside TRAIN does not restart the training count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- FIFO ----------------
    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign empty      = (fifo_level == '0);
    assign s_tready   = (state != RST_HOLD) && !full;
    assign wr_en      = s_tvalid && s_tready;
    assign rd_en      = (state == STREAM) && !empty;
    // Entering TRAIN discards everything queued, including a word written on
    // the same edge.
    assign flush      = (state_next == TRAIN) && (state != TRAIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end

`ifdef SYZYGY_DAC_TX_TWOS_COMP_EN
    // MID_WORD has exactly the sample MSBs set, so XOR flips each sign bit.
    assign rd_word = mem[rd_ptr[AW-1:0]] ^ MID_WORD;
`else
    assign rd_word = mem[rd_ptr[AW-1:0]];
`endif

    // ---------------- Output pipeline ----------------
    // Two register stages from the FIFO to the pins. A word written into an
    // empty FIFO during STREAM is read one edge later and reaches dac_word on
    // the edge after that.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_word     <= MID_WORD;
            dac_word      <= MID_WORD;
            underflow_cnt <= '0;
        end else begin
            dac_word <= pipe_word;
            case (state)
                TRAIN:   pipe_word <= TRAIN_WORD;
                STREAM:  pipe_word <= empty ? MID_WORD : rd_word;
                default: pipe_word <= MID_WORD;
            endcase
            if (state == STREAM && empty && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

    assign oserdes_rst = (state == RST_HOLD);
    assign streaming   = (state == STREAM);
    // One DDR edge per bit slot once the serializers are out of reset.
    assign dci_pattern = (state == RST_HOLD) ? 8'h00 : 8'h55;
    assign fsm_state   = state;

endmodule
